instr_fetch_queue: RTL
======================

Name: instr_fetch_queue

Overview:
- Parametrised successor to the single-entry instruction latch in the multicycle core.
- Buffers up to DEPTH fetched instructions, each with its PC, between memory fetch and decode/control.
- Uses valid/ready handshakes on both sides, plus a synchronous flush for branches, jumps and traps.
- Lets fetch run ahead of the multicycle execute FSM.

Parameters:
- XLEN, 32, width of the instruction word and the PC.
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- RESET_INSTR, 32'h0000_0000, value driven on pop_instr whenever the queue is empty.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- flush  in  1  synchronous discard of all entries.
- push_valid  in  1  fetch side offers an entry.
- push_ready  out  1  queue can accept an entry this cycle.
- push_instr  in  XLEN  instruction word from memory.
- push_pc  in  XLEN  PC of push_instr.
- pop_valid  out  1  head entry is available.
- pop_ready  in  1  decode/control consumes the head.
- pop_instr  out  XLEN  head instruction.
- pop_pc  out  XLEN  head PC.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State:
  - storage array of DEPTH x {pc, instr}
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH
  - count register
- Reset (same edge, overrides everything):
  - wr_ptr = rd_ptr = count = 0
  - pop_valid = 0, push_ready = 1
  - pop_instr = RESET_INSTR, pop_pc = 0
  - storage contents don't-care
- Push fires when push_valid && push_ready:
  - entry written at wr_ptr; wr_ptr increments.
- Pop fires when pop_valid && pop_ready:
  - rd_ptr increments.
- push_ready = (count != DEPTH). It depends only on registered state; a pop in the same cycle does not open a slot when full.
- pop_valid = (count != 0).
- pop_instr and pop_pc are combinational reads of storage[rd_ptr]. When count == 0 they are forced to RESET_INSTR and 0.
- Latency without the optional feature: an entry pushed at edge N is visible at pop from cycle N+1.
- Simultaneous push and pop when 0 < count < DEPTH: both fire and count is unchanged.
- Push into an empty queue: count goes 0 to 1.
- Pop of the last entry: count goes 1 to 0 and outputs return to RESET_INSTR/0 next cycle.
- Flush (when reset is low):
  - next state has count = 0 and wr_ptr = rd_ptr = 0.
  - Any push or pop in the flush cycle is discarded.
  - push_ready stays 1 during flush.
  - pop_valid is 0 from the next cycle.
- Order of operations (one combined update, no lost entries): pointer wrap DEPTH-1 to 0.
- Priority: reset > flush > push/pop.
- Assertions (simulation only): count <= DEPTH; no push accepted while count == DEPTH.

Optional Feature:
- Macro: INSTR_FETCH_QUEUE_BYPASS_EN.
- Defined: when count == 0 and push_valid is high (and flush is low):
  - pop_valid = 1 in the same cycle; pop_instr/pop_pc = push_instr/push_pc.
  - If pop_ready is also high, the entry is consumed and not stored; count stays 0 and pointers are unchanged.
  - Zero-latency path.
- Not defined: registered-only path, one-cycle latency, pop outputs never depend on push inputs combinationally.

Decomposition:
- Package ifq_pkg:
  - typedef fetch_entry_t as packed struct {pc, instr}.
  - localparam RESET_INSTR default.
  - Helper function ptr_inc(ptr) for modulo-DEPTH increment.
- Sub-module ifq_storage: DEPTH x fetch_entry_t register array, no reset, with one write port and one asynchronous read port.
- instr_fetch_queue holds pointers, count, handshake logic, flush and bypass.

Test Plan:
1. Reset, then push 0x00500093/PC 0x0 and 0x00A00113/PC 0x4 on consecutive cycles, pop_ready=0:
   -> count=2, pop_instr=0x00500093, pop_pc=0x0; pop once -> head becomes 0x00A00113/PC 0x4.
2. Push 4 entries (PC 0x0..0xC) with DEPTH=4, no pops:
   -> push_ready=0, count=4; a fifth push_valid is ignored; popping all returns PCs 0x0, 0x4, 0x8, 0xC in order.
3. Hold count=2, push and pop in the same cycle 6 times:
   -> count stays 2, pointers wrap past 3, pop order matches push order.
4. Queue holding 3 entries, flush=1 with push_valid=1 and pop_ready=1:
   -> next cycle count=0, pop_valid=0, pop_instr=0x00000000; the pushed entry is absent.
5. Reset asserted mid-stream with count=3 and push_valid=1:
   -> next cycle count=0, push_ready=1, pop_pc=0.
6. With INSTR_FETCH_QUEUE_BYPASS_EN, empty queue, push 0x00000013/PC 0x100 with pop_ready=1:
   -> pop_valid=1 with that data in the same cycle, count stays 0.
   -> Without the macro: pop_valid=0 that cycle and the entry pops the following cycle.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// Entry layout and default reset instruction live here.
package ifq_pkg;

  localparam int IFQ_XLEN = 32;
  localparam logic [IFQ_XLEN-1:0] IFQ_RESET_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [IFQ_XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the fetch queue: one write port, async read.
// Contents are not reset; occupancy is tracked by the owner.
module ifq_storage
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [PW-1:0] wr_addr,
  input  fetch_entry_t wr_data,
  input  logic [PW-1:0] rd_addr,
  output fetch_entry_t rd_data
);

  fetch_entry_t mem [DEPTH];

  // capture one entry per accepted push
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue between memory fetch and decode.
// Define INSTR_FETCH_QUEUE_BYPASS_EN for an empty-queue bypass.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int XLEN = IFQ_XLEN,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_INSTR = IFQ_RESET_INSTR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [XLEN-1:0]          push_instr,
  input  logic [XLEN-1:0]          push_pc,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [XLEN-1:0]          pop_instr,
  output logic [XLEN-1:0]          pop_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  fetch_entry_t  wdata;
  fetch_entry_t  rdata;
  logic          empty;
  logic          full;
  logic          byp;
  logic          byp_take;
  logic          do_push;
  logic          do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  assign push_ready = !full;

`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
  assign byp = empty && push_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign byp_take  = byp && pop_ready;
  assign pop_valid = !empty || byp;
  assign count     = cnt;

  // a bypassed entry that is consumed never touches storage
  assign do_push = push_valid && push_ready && !byp_take;
  assign do_pop  = pop_valid && pop_ready && !byp_take;

  assign wdata.pc    = push_pc;
  assign wdata.instr = push_instr;

  ifq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (do_push && !flush && !reset),
    .wr_addr (wr_ptr),
    .wr_data (wdata),
    .rd_addr (rd_ptr),
    .rd_data (rdata)
  );

  // head outputs: bypass, stored head, or idle values when empty
  always_comb begin
    pop_instr = RESET_INSTR;
    pop_pc    = '0;
    if (byp) begin
      pop_instr = push_instr;
      pop_pc    = push_pc;
    end else if (!empty) begin
      pop_instr = rdata.instr;
      pop_pc    = rdata.pc;
    end
  end

  // pointer and occupancy update: reset > flush > push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= PW'(ptr_inc(int'(wr_ptr), DEPTH));
      if (do_pop)  rd_ptr <= PW'(ptr_inc(int'(rd_ptr), DEPTH));
      if (do_push && !do_pop) cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

  // occupancy sanity in simulation
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (cnt <= CW'(DEPTH));
      assert (!(push_valid && push_ready && full));
    end
  end

endmodule
